pc_step_ctrl: RTL and testbench

//  Upstream of pc: drives its 'in' and 'enable' for single-step execution.

---
 rtl/pc_ctrl_pkg.sv | 47 ++++
 rtl/step_debounce.sv | 54 +++++
 rtl/pc_step_ctrl.sv | 134 +++++++++++++
 tb/tb_pc_step_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the single-step pc controller:
//   state_t          FSM encoding (IDLE, STEP, SETTLE, REDIRECT, RELEASE)
//   PC_INCR          sequential pc increment
//   JUMP_IDX_W       width of the j-type target index field
//   BR_IMM_W         width of the branch immediate field
//   redirect_target  target address issued by the second (redirect) pulse
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_REDIRECT,
    ST_RELEASE
  } state_t;

  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam int          JUMP_IDX_W = 26;
  localparam int          BR_IMM_W   = 16;

  // Jump has priority over branch. A not-taken branch reloads the current
  // address so the pc sees a second load and returns to its idle state.
  function automatic logic [31:0] redirect_target(
    input logic [31:0] pc_q,
    input logic [31:0] instr,
    input logic        jump,
    input logic        branch,
    input logic        zero
  );
    logic [31:0] seq;
    logic [31:0] br_off;
    seq    = pc_q + PC_INCR;
    br_off = {{(32-BR_IMM_W-2){instr[BR_IMM_W-1]}}, instr[BR_IMM_W-1:0], 2'b00};
    if (jump)
      redirect_target = {seq[31:28], instr[JUMP_IDX_W-1:0], 2'b00};
    else if (branch && zero)
      redirect_target = seq + br_off;
    else if (branch)
      redirect_target = pc_q;
    else
      redirect_target = seq;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// -----------------------------------------------------------------------------
// step_debounce
// Two-flop synchroniser followed by a stability counter for the step button.
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples that disagree with the current level.
// Ports:
//   Clk      in   clock
//   Rst      in   synchronous reset, active-low
//   StepBtn  in   raw asynchronous button, high = pressed
//   Level    out  debounced button level
//   Rise     out  one-cycle pulse in the cycle Level becomes 1
// -----------------------------------------------------------------------------
module step_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic StepBtn,
  output logic Level,
  output logic Rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the synchroniser chain depends on it.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      Level <= 1'b0;
      Rise  <= 1'b0;
    end else begin
      sync1 <= StepBtn;
      sync2 <= sync1;
      Rise  <= 1'b0;
      if (sync2 == Level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        Level <= sync2;
        Rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_step_ctrl.sv
// -----------------------------------------------------------------------------
// pc_step_ctrl
// Single-step driver for the pc register. Each debounced button press issues
// one enable pulse loading PcQ+4; if the newly fetched instruction is a jump
// or branch a second redirect pulse follows two cycles later with the target.
// Optional feature macro: STEP_AUTORUN_EN adds the AutoRun input and a RUN_DIV
// divider whose expiry in IDLE acts as a press.
// Ports:
//   Clk        in   clock
//   Rst        in   synchronous reset, active-low
//   StepBtn    in   raw step button
//   PcQ        in   current pc value
//   Instr      in   instruction at PcQ
//   Jump       in   decoded jump
//   Branch     in   decoded branch
//   Zero       in   ALU zero (branch taken when Branch & Zero)
//   NextPc     out  value for pc.in (combinational)
//   PcEnable   out  pc.enable, one-cycle pulses
//   StepCount  out  completed steps, wraps
//   AutoRun    in   free-run request (STEP_AUTORUN_EN only)
// -----------------------------------------------------------------------------
module pc_step_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RUN_DIV         = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             StepBtn,
  input  logic [31:0]      PcQ,
  input  logic [31:0]      Instr,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero,
  output logic [31:0]      NextPc,
  output logic             PcEnable,
  output logic [CNT_W-1:0] StepCount
`ifdef STEP_AUTORUN_EN
  ,
  input  logic             AutoRun
`endif
);

  state_t state;
  logic   level;
  logic   rise;
  logic   press;
  logic   release_ok;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clk    (Clk),
    .Rst    (Rst),
    .StepBtn(StepBtn),
    .Level  (level),
    .Rise   (rise)
  );

`ifdef STEP_AUTORUN_EN
  localparam int RW = $clog2(RUN_DIV + 1);

  logic [RW-1:0] run_cnt;
  logic          run_tick;

  // The divider only runs while parked in IDLE, so every auto step waits a
  // full RUN_DIV period after the previous one completes.
  always_ff @(posedge Clk) begin
    if (!Rst || state != ST_IDLE || !AutoRun || run_tick)
      run_cnt <= '0;
    else
      run_cnt <= run_cnt + 1'b1;
  end

  assign run_tick   = (state == ST_IDLE) && AutoRun && (run_cnt == RW'(RUN_DIV - 1));
  assign press      = rise | run_tick;
  assign release_ok = !level | AutoRun;
`else
  assign press      = rise;
  assign release_ok = !level;
`endif

  // NOTE: the default assignment first means every path through this block
  // drives NextPc, so no latch is inferred.
  always_comb begin
    NextPc = PcQ + PC_INCR;
    if (state == ST_REDIRECT)
      NextPc = redirect_target(PcQ, Instr, Jump, Branch, Zero);
  end

  // PcEnable is registered: it is set on the transition into STEP or REDIRECT
  // and cleared by default, which guarantees isolated single-cycle pulses.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= ST_IDLE;
      PcEnable  <= 1'b0;
      StepCount <= '0;
    end else begin
      PcEnable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state    <= ST_STEP;
            PcEnable <= 1'b1;
          end
        end
        ST_STEP: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (Jump || Branch) begin
            state    <= ST_REDIRECT;
            PcEnable <= 1'b1;
          end else begin
            StepCount <= StepCount + 1'b1;
            state     <= ST_RELEASE;
          end
        end
        ST_REDIRECT: begin
          StepCount <= StepCount + 1'b1;
          state     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (release_ok)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_step_ctrl
// Bench for pc_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8. A behavioural pc
// register and a one-entry instruction memory close the loop around the DUT.
// Expected NextPc values for each pulse are queued by the scenario tasks and
// popped by a monitor that samples on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_step_ctrl;
  import pc_ctrl_pkg::*;

  localparam int          DEB       = 4;
  localparam int          RUN_DIV   = 8;
  localparam int          CNT_W     = 16;
  localparam logic [31:0] ADD_INSTR = 32'h0022_0820;
  localparam logic [31:0] J_INSTR   = 32'h0800_0040;
  localparam logic [31:0] BEQ_INSTR = 32'h1000_FFFE;
  localparam logic [31:0] NO_ADDR   = 32'hFFFF_FFF0;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             StepBtn = 1'b0;
  logic [31:0]      PcQ = 32'h0;
  logic [31:0]      Instr;
  logic             Jump;
  logic             Branch;
  logic             Zero = 1'b0;
  logic [31:0]      NextPc;
  logic             PcEnable;
  logic [CNT_W-1:0] StepCount;
`ifdef STEP_AUTORUN_EN
  logic             AutoRun = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  pc_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (RUN_DIV),
    .CNT_W          (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .StepBtn  (StepBtn),
    .PcQ      (PcQ),
    .Instr    (Instr),
    .Jump     (Jump),
    .Branch   (Branch),
    .Zero     (Zero),
    .NextPc   (NextPc),
    .PcEnable (PcEnable),
    .StepCount(StepCount)
`ifdef STEP_AUTORUN_EN
    ,
    .AutoRun  (AutoRun)
`endif
  );

  // Behavioural pc register plus a bench-side load port.
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  always @(posedge Clk) begin
    if (pc_load)       PcQ <= pc_load_val;
    else if (PcEnable) PcQ <= NextPc;
  end

  // One special instruction at tgt_addr, add everywhere else; simple decode.
  logic [31:0] tgt_addr  = NO_ADDR;
  logic [31:0] tgt_instr = ADD_INSTR;
  assign Instr  = (PcQ == tgt_addr) ? tgt_instr : ADD_INSTR;
  assign Jump   = (Instr[31:26] == 6'h02);
  assign Branch = (Instr[31:26] == 6'h04);

  // Scoreboard and pulse monitor.
  logic [31:0] exp_q[$];
  int          pulse_cyc[$];
  logic [31:0] exp_v;
  logic        prev_en = 1'b0;
  bit          auto_mode = 1'b0;

  always @(negedge Clk) begin
    if (PcEnable === 1'b1) begin
      pulse_cyc.push_back(cyc);
      checks++;
      if (prev_en === 1'b1) begin
        errors++;
        $display("FAIL back_to_back_pulse cycle=%0d got two consecutive pulses, required isolated", cyc);
      end
      checks++;
      if (auto_mode) begin
        exp_v = PcQ + 32'd4;
        if (NextPc !== exp_v) begin
          errors++;
          $display("FAIL auto_next_pc got %h required %h", NextPc, exp_v);
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d NextPc=%h required no pulse", cyc, NextPc);
      end else begin
        exp_v = exp_q.pop_front();
        if (NextPc !== exp_v) begin
          errors++;
          $display("FAIL pulse_next_pc got %h required %h", NextPc, exp_v);
        end
      end
    end
    prev_en = PcEnable;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load     = 1'b1;
    tick(1);
    pc_load     = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge Clk);
      i++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required 0 within %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic release_btn();
    StepBtn = 1'b0;
    tick(14);
  endtask

  task automatic check_steps(input string name, input logic [CNT_W-1:0] base,
                             input int n_steps, input int n_pulses);
    logic [CNT_W-1:0] exp_cnt;
    exp_cnt = base + CNT_W'(n_steps);
    checks++;
    if (StepCount !== exp_cnt) begin
      errors++;
      $display("FAIL %s_step_count got %0d required %0d", name, StepCount, exp_cnt);
    end
    checks++;
    if (pulse_cyc.size() != n_pulses) begin
      errors++;
      $display("FAIL %s_pulse_count got %0d required %0d", name, pulse_cyc.size(), n_pulses);
    end
  endtask

  task automatic test_reset();
    Rst     = 1'b0;
    StepBtn = 1'b1;
    load_pc(32'h0);
    tick(2);
    @(negedge Clk);
    checks++;
    if (PcEnable !== 1'b0) begin
      errors++; $display("FAIL reset_pc_enable got %b required 0", PcEnable);
    end
    checks++;
    if (StepCount !== '0) begin
      errors++; $display("FAIL reset_step_count got %0d required 0", StepCount);
    end
    checks++;
    if (NextPc !== 32'h4) begin
      errors++; $display("FAIL reset_next_pc got %h required 00000004", NextPc);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d required IDLE", dut.state);
    end
    tick(1);
    Rst     = 1'b1;
    StepBtn = 1'b0;
    pulse_cyc.delete();
    tick(20);
    check_steps("reset_quiet", '0, 0, 0);
  endtask

  task automatic test_sequential();
    logic [CNT_W-1:0] base;
    load_pc(32'h10);
    base = StepCount;
    pulse_cyc.delete();
    exp_q.push_back(32'h14);
    StepBtn = 1'b1;
    wait_drain("sequential", 40);
    tick(50);
    check_steps("sequential_hold", base, 1, 1);
    release_btn();
  endtask

  task automatic test_jump();
    logic [CNT_W-1:0] base;
    load_pc(32'h10);
    tgt_addr  = 32'h14;
    tgt_instr = J_INSTR;
    base = StepCount;
    pulse_cyc.delete();
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h100);
    StepBtn = 1'b1;
    wait_drain("jump", 40);
    tick(5);
    check_steps("jump", base, 1, 2);
    if (pulse_cyc.size() == 2) begin
      checks++;
      if (pulse_cyc[1] - pulse_cyc[0] != 2) begin
        errors++;
        $display("FAIL jump_redirect_gap got %0d required 2", pulse_cyc[1] - pulse_cyc[0]);
      end
    end
    release_btn();
    tgt_addr = NO_ADDR;
  endtask

  task automatic test_branch(input logic zero_v, input logic [31:0] target);
    logic [CNT_W-1:0] base;
    load_pc(32'h1C);
    tgt_addr  = 32'h20;
    tgt_instr = BEQ_INSTR;
    Zero      = zero_v;
    base = StepCount;
    pulse_cyc.delete();
    exp_q.push_back(32'h20);
    exp_q.push_back(target);
    StepBtn = 1'b1;
    wait_drain(zero_v ? "branch_taken" : "branch_not_taken", 40);
    tick(5);
    check_steps(zero_v ? "branch_taken" : "branch_not_taken", base, 1, 2);
    release_btn();
    tgt_addr = NO_ADDR;
    Zero     = 1'b0;
  endtask

  task automatic test_bounce();
    logic [CNT_W-1:0] base;
    load_pc(32'h40);
    base = StepCount;
    pulse_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      StepBtn = ~StepBtn;
      tick(2);
    end
    checks++;
    if (pulse_cyc.size() != 0) begin
      errors++;
      $display("FAIL bounce_during_chatter got %0d pulses required 0", pulse_cyc.size());
    end
    exp_q.push_back(32'h44);
    StepBtn = 1'b1;
    wait_drain("bounce", 40);
    tick(20);
    check_steps("bounce", base, 1, 1);
    release_btn();
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] base;
    load_pc(32'hFFFF_FFFC);
    @(negedge Clk);
    checks++;
    if (NextPc !== 32'h0) begin
      errors++; $display("FAIL wrap_next_pc got %h required 00000000", NextPc);
    end
    #1;
    base = StepCount;
    pulse_cyc.delete();
    exp_q.push_back(32'h0);
    StepBtn = 1'b1;
    wait_drain("wrap", 40);
    tick(5);
    check_steps("wrap", base, 1, 1);
    release_btn();
  endtask

  task automatic test_reset_abort();
    int i = 0;
    load_pc(32'h10);
    tgt_addr  = 32'h14;
    tgt_instr = J_INSTR;
    pulse_cyc.delete();
    exp_q.push_back(32'h14);
    StepBtn = 1'b1;
    while (pulse_cyc.size() == 0 && i < 40) begin
      @(posedge Clk);
      i++;
    end
    #1;
    checks++;
    if (dut.state !== ST_SETTLE) begin
      errors++; $display("FAIL abort_in_settle got state %0d required SETTLE", dut.state);
    end
    Rst     = 1'b0;
    StepBtn = 1'b0;
    tick(1);
    checks++;
    if (dut.state !== ST_IDLE || PcEnable !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got state %0d en %b required IDLE 0", dut.state, PcEnable);
    end
    tick(2);
    Rst = 1'b1;
    tick(15);
    check_steps("abort", '0, 0, 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL abort_pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
    tgt_addr = NO_ADDR;
  endtask

`ifdef STEP_AUTORUN_EN
  task automatic test_autorun();
    logic [CNT_W-1:0] base;
    int               n;
    load_pc(32'h200);
    base = StepCount;
    pulse_cyc.delete();
    auto_mode = 1'b1;
    AutoRun   = 1'b1;
    tick(60);
    AutoRun   = 1'b0;
    tick(15);
    auto_mode = 1'b0;
    n = pulse_cyc.size();
    checks++;
    if (n < 3 || n > 7) begin
      errors++; $display("FAIL autorun_pulses got %0d required 3..7", n);
    end
    check_steps("autorun", base, n, n);
    for (int k = 1; k < n; k++) begin
      checks++;
      if (pulse_cyc[k] - pulse_cyc[k-1] < RUN_DIV) begin
        errors++;
        $display("FAIL autorun_gap got %0d required >= %0d", pulse_cyc[k] - pulse_cyc[k-1], RUN_DIV);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch(1'b1, 32'h1C);
    test_branch(1'b0, 32'h20);
    test_bounce();
    test_wrap();
    test_reset_abort();
`ifdef STEP_AUTORUN_EN
    test_autorun();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
